// File: rtl/apb_timer_cmd_master.sv
// -----------------------------------------------------------------------------
// apb_timer_cmd_master
//   APB requester for the timer unit's completer port. Takes single-beat
//   valid/ready commands, runs one APB SETUP/ACCESS transfer per command and
//   returns read data plus error status on a valid/ready response channel.
//
//   Optional feature macro: APB_MST_TIMEOUT_EN
//     defined   : a 16-bit wait-state counter aborts an ACCESS phase after
//                 TIMEOUT_CYCLES cycles without PREADY (rsp_err=1, rsp_timeout=1)
//     undefined : ACCESS waits forever, rsp_timeout_o is tied to 0
//
//   Ports
//     clk_i, rst_i            clock, synchronous active-high reset
//     cmd_*                   command channel in (valid/ready, write, addr, wdata)
//     rsp_*                   response channel out (valid/ready, rdata, err, timeout)
//     busy_o                  high whenever the FSM is not IDLE
//     psel_o .. pwdata_o      APB request signals to the completer
//     pready_i .. pslverr_i   APB completer response signals
// -----------------------------------------------------------------------------
module apb_timer_cmd_master #(
   parameter int ADDR_WIDTH     = 12,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  cmd_valid_i,
   output logic                  cmd_ready_o,
   input  logic                  cmd_write_i,
   input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
   input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
   output logic                  rsp_valid_o,
   input  logic                  rsp_ready_i,
   output logic [DATA_WIDTH-1:0] rsp_rdata_o,
   output logic                  rsp_err_o,
   output logic                  rsp_timeout_o,
   output logic                  busy_o,
   output logic                  psel_o,
   output logic                  penable_o,
   output logic                  pwrite_o,
   output logic [ADDR_WIDTH-1:0] paddr_o,
   output logic [DATA_WIDTH-1:0] pwdata_o,
   input  logic                  pready_i,
   input  logic [DATA_WIDTH-1:0] prdata_i,
   input  logic                  pslverr_i
);

   typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS, ST_RESP} state_t;

   state_t                r_state;
   logic                  r_psel;
   logic                  r_penable;
   logic                  r_pwrite;
   logic [ADDR_WIDTH-1:0] r_paddr;
   logic [DATA_WIDTH-1:0] r_pwdata;
   logic                  r_rsp_valid;
   logic [DATA_WIDTH-1:0] r_rsp_rdata;
   logic                  r_rsp_err;
   logic                  w_unused;

   // Byte-lane bits of the command address never reach PADDR.
   assign w_unused = &{1'b0, cmd_addr_i[1:0], (TIMEOUT_CYCLES != 0)};

`ifdef APB_MST_TIMEOUT_EN
   logic        r_rsp_timeout;
   logic [15:0] r_wait_cnt;
   logic [15:0] w_wait_cnt_nxt;
   logic        w_timeout_hit;

   // The limit is reached in the cycle whose missing PREADY would bring the
   // count to TIMEOUT_CYCLES; a PREADY in that same cycle still completes.
   assign w_wait_cnt_nxt = r_wait_cnt + 16'd1;
   assign w_timeout_hit  = (w_wait_cnt_nxt == 16'(TIMEOUT_CYCLES));
   assign rsp_timeout_o  = r_rsp_timeout;
`else
   assign rsp_timeout_o  = 1'b0;
`endif

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state     <= ST_IDLE;
         r_psel      <= 1'b0;
         r_penable   <= 1'b0;
         r_pwrite    <= 1'b0;
         r_paddr     <= '0;
         r_pwdata    <= '0;
         r_rsp_valid <= 1'b0;
         r_rsp_rdata <= '0;
         r_rsp_err   <= 1'b0;
`ifdef APB_MST_TIMEOUT_EN
         r_rsp_timeout <= 1'b0;
         r_wait_cnt    <= '0;
`endif
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (cmd_valid_i) begin
                  r_pwrite <= cmd_write_i;
                  r_paddr  <= {cmd_addr_i[ADDR_WIDTH-1:2], 2'b00};
                  r_pwdata <= cmd_wdata_i;
                  r_psel   <= 1'b1;
                  r_state  <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               r_penable <= 1'b1;
`ifdef APB_MST_TIMEOUT_EN
               r_wait_cnt <= '0;
`endif
               r_state   <= ST_ACCESS;
            end
            ST_ACCESS: begin
               if (pready_i) begin
                  r_psel      <= 1'b0;
                  r_penable   <= 1'b0;
                  r_rsp_valid <= 1'b1;
                  r_rsp_rdata <= r_pwrite ? '0 : prdata_i;
                  r_rsp_err   <= pslverr_i;
                  r_state     <= ST_RESP;
               end
`ifdef APB_MST_TIMEOUT_EN
               else if (w_timeout_hit) begin
                  r_psel        <= 1'b0;
                  r_penable     <= 1'b0;
                  r_rsp_valid   <= 1'b1;
                  r_rsp_rdata   <= '0;
                  r_rsp_err     <= 1'b1;
                  r_rsp_timeout <= 1'b1;
                  r_state       <= ST_RESP;
               end else begin
                  r_wait_cnt <= w_wait_cnt_nxt;
               end
`endif
            end
            ST_RESP: begin
               if (rsp_ready_i) begin
                  r_rsp_valid <= 1'b0;
                  r_rsp_rdata <= '0;
                  r_rsp_err   <= 1'b0;
`ifdef APB_MST_TIMEOUT_EN
                  r_rsp_timeout <= 1'b0;
`endif
                  r_state     <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign cmd_ready_o = (r_state == ST_IDLE);
   assign busy_o      = (r_state != ST_IDLE);
   assign psel_o      = r_psel;
   assign penable_o   = r_penable;
   assign pwrite_o    = r_pwrite;
   assign paddr_o     = r_paddr;
   assign pwdata_o    = r_pwdata;
   assign rsp_valid_o = r_rsp_valid;
   assign rsp_rdata_o = r_rsp_rdata;
   assign rsp_err_o   = r_rsp_err;

endmodule

// File: tb/tb_apb_timer_cmd_master.sv
// -----------------------------------------------------------------------------
// tb_apb_timer_cmd_master
//   Bench for apb_timer_cmd_master: reset state, a table of directed
//   transfers, hand-written timeout / mid-transfer reset sequences and a run
//   of random transfers checked against a transaction-level model.
//   Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_apb_timer_cmd_master;

`ifdef APB_MST_TIMEOUT_EN
   localparam int TB_TO = 8;
`else
   localparam int TB_TO = 255;
`endif

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        cmd_valid_i;
   logic        cmd_ready_o;
   logic        cmd_write_i;
   logic [11:0] cmd_addr_i;
   logic [31:0] cmd_wdata_i;
   logic        rsp_valid_o;
   logic        rsp_ready_i;
   logic [31:0] rsp_rdata_o;
   logic        rsp_err_o;
   logic        rsp_timeout_o;
   logic        busy_o;
   logic        psel_o;
   logic        penable_o;
   logic        pwrite_o;
   logic [11:0] paddr_o;
   logic [31:0] pwdata_o;
   logic        pready_i;
   logic [31:0] prdata_i;
   logic        pslverr_i;

   int    n_checks = 0;
   int    n_fail   = 0;
   string ctx      = "reset";

   apb_timer_cmd_master #(
      .ADDR_WIDTH(12), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TB_TO)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
      .cmd_write_i(cmd_write_i), .cmd_addr_i(cmd_addr_i), .cmd_wdata_i(cmd_wdata_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
      .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o),
      .busy_o(busy_o), .psel_o(psel_o), .penable_o(penable_o), .pwrite_o(pwrite_o),
      .paddr_o(paddr_o), .pwdata_o(pwdata_o),
      .pready_i(pready_i), .prdata_i(prdata_i), .pslverr_i(pslverr_i)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      repeat (50000) @(posedge clk_i);
      $display("FAIL watchdog: simulation still running after 50000 cycles");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s/%s: got %0h expected %0h", ctx, name, act, exp);
      end
   endtask

   // Command fields wiggle freely while the master is busy; it must ignore them.
   task automatic scramble_cmd();
      cmd_valid_i = 1'($urandom);
      cmd_write_i = 1'($urandom);
      cmd_addr_i  = 12'($urandom);
      cmd_wdata_i = $urandom;
   endtask

   // Transaction-level expectation: word-aligned address, read data only for
   // completed reads, error from PSLVERR, or a forced error on timeout.
   function automatic void ref_model(input logic wr, input logic [11:0] addr,
                                     input logic [31:0] prd, input logic slv, input bit to,
                                     output logic [11:0] paddr, output logic [31:0] rdata,
                                     output logic err, output logic tmo);
      paddr = 12'((int'(addr) / 4) * 4);
      if (to) begin
         rdata = 32'h0; err = 1'b1; tmo = 1'b1;
      end else begin
         rdata = wr ? 32'h0 : prd; err = slv; tmo = 1'b0;
      end
   endfunction

   // Entered and left at a falling edge with the master IDLE. The command is
   // presented immediately, so back-to-back calls test acceptance in the cycle
   // right after the response handshake.
   task automatic run_txn(input logic wr, input logic [11:0] addr, input logic [31:0] wdata,
                          input int waits, input logic [31:0] prd, input logic slv,
                          input int stall, input bit expect_to,
                          input logic [11:0] e_paddr, input logic [31:0] e_rdata,
                          input logic e_err, input logic e_to);
      int  n_acc;
      bit  last;
      n_acc = expect_to ? TB_TO : waits + 1;
      cmd_valid_i = 1'b1; cmd_write_i = wr; cmd_addr_i = addr; cmd_wdata_i = wdata;
      rsp_ready_i = 1'b0; pready_i = 1'b0;
      chk("cmd_ready_idle", 64'(cmd_ready_o), 64'(1));
      @(negedge clk_i);                               // SETUP (T+1)
      scramble_cmd();
      pready_i = 1'($urandom); pslverr_i = 1'($urandom); prdata_i = $urandom;
      chk("setup_psel", 64'(psel_o), 64'(1));
      chk("setup_penable", 64'(penable_o), 64'(0));
      chk("setup_pwrite", 64'(pwrite_o), 64'(wr));
      chk("setup_paddr", 64'(paddr_o), 64'(e_paddr));
      chk("setup_pwdata", 64'(pwdata_o), 64'(wdata));
      chk("setup_busy", 64'(busy_o), 64'(1));
      chk("setup_cmd_ready", 64'(cmd_ready_o), 64'(0));
      for (int i = 0; i < n_acc; i++) begin
         @(negedge clk_i);                            // ACCESS cycle i (T+2+i)
         chk("acc_psel_penable", 64'({psel_o, penable_o}), 64'(2'b11));
         chk("acc_hold", 64'({pwrite_o, paddr_o, pwdata_o}), 64'({wr, e_paddr, wdata}));
         chk("acc_rsp_valid", 64'(rsp_valid_o), 64'(0));
         last = !expect_to && (i == n_acc - 1);
         pready_i  = last;
         pslverr_i = last ? slv : 1'($urandom);
         prdata_i  = last ? prd : $urandom;
         scramble_cmd();
      end
      @(negedge clk_i);                               // RESP
      pready_i = 1'($urandom); pslverr_i = 1'($urandom); prdata_i = $urandom;
      chk("resp_valid", 64'(rsp_valid_o), 64'(1));
      chk("resp_apb_idle", 64'({psel_o, penable_o}), 64'(0));
      chk("resp_rdata", 64'(rsp_rdata_o), 64'(e_rdata));
      chk("resp_err_to", 64'({rsp_err_o, rsp_timeout_o}), 64'({e_err, e_to}));
      chk("resp_cmd_ready", 64'(cmd_ready_o), 64'(0));
      for (int s = 0; s < stall; s++) begin
         @(negedge clk_i);
         scramble_cmd();
         pready_i = 1'($urandom); pslverr_i = 1'($urandom);
         chk("stall_hold", 64'({rsp_valid_o, rsp_err_o, rsp_timeout_o, rsp_rdata_o}),
             64'({1'b1, e_err, e_to, e_rdata}));
         chk("stall_cmd_ready", 64'(cmd_ready_o), 64'(0));
      end
      rsp_ready_i = 1'b1; cmd_valid_i = 1'b0;
      @(negedge clk_i);                               // back in IDLE
      rsp_ready_i = 1'b0; pready_i = 1'b0; pslverr_i = 1'b0;
      chk("post_rsp_valid", 64'(rsp_valid_o), 64'(0));
      chk("post_cmd_ready", 64'(cmd_ready_o), 64'(1));
      chk("post_busy", 64'(busy_o), 64'(0));
   endtask

   typedef struct {
      logic        wr;
      logic [11:0] addr;
      logic [31:0] wdata;
      int          waits;
      logic [31:0] prdata;
      logic        slverr;
      int          stall;
      logic [11:0] e_paddr;
      logic [31:0] e_rdata;
      logic        e_err;
   } vec_t;

   vec_t vecs[6];

   initial begin
      logic [11:0] m_paddr;
      logic [31:0] m_rdata;
      logic        m_err, m_to;
      logic        r_wr, r_slv;
      logic [11:0] r_addr;
      logic [31:0] r_wd, r_prd;

      vecs[0] = '{1'b1, 12'h004, 32'h0000_00FF, 0, 32'h1234_5678, 1'b0, 0, 12'h004, 32'h0, 1'b0};
      vecs[1] = '{1'b0, 12'h00B, 32'h5555_0000, 3, 32'hDEAD_BEEF, 1'b0, 0, 12'h008, 32'hDEAD_BEEF, 1'b0};
      vecs[2] = '{1'b1, 12'h010, 32'hA5A5_A5A5, 1, 32'hFFFF_FFFF, 1'b1, 0, 12'h010, 32'h0, 1'b1};
      vecs[3] = '{1'b0, 12'hFFF, 32'h0,         0, 32'h0BAD_F00D, 1'b1, 5, 12'hFFC, 32'h0BAD_F00D, 1'b1};
      vecs[4] = '{1'b0, 12'h003, 32'h0,         7, 32'h0000_0001, 1'b0, 2, 12'h000, 32'h0000_0001, 1'b0};
      vecs[5] = '{1'b1, 12'h7FE, 32'hFFFF_FFFF, 2, 32'h0,         1'b0, 5, 12'h7FC, 32'h0, 1'b0};

      // Reset with noise on every input.
      rst_i = 1'b1; cmd_valid_i = 1'b1; cmd_write_i = 1'b1; cmd_addr_i = 12'hABC;
      cmd_wdata_i = 32'hFFFF_FFFF; rsp_ready_i = 1'b0; pready_i = 1'b1;
      prdata_i = 32'hFFFF_FFFF; pslverr_i = 1'b1;
      repeat (3) @(negedge clk_i);
      chk("rst_apb", 64'({psel_o, penable_o, pwrite_o}), 64'(0));
      chk("rst_paddr_pwdata", 64'({paddr_o, pwdata_o}), 64'(0));
      chk("rst_rsp", 64'({rsp_valid_o, rsp_err_o, rsp_timeout_o, rsp_rdata_o}), 64'(0));
      chk("rst_busy", 64'(busy_o), 64'(0));
      rst_i = 1'b0; cmd_valid_i = 1'b0; pready_i = 1'b0; pslverr_i = 1'b0;
      @(negedge clk_i);
      chk("rst_cmd_ready", 64'(cmd_ready_o), 64'(1));
      chk("rst_idle_psel", 64'(psel_o), 64'(0));

      // Directed table, run back to back.
      for (int v = 0; v < 6; v++) begin
         ctx = $sformatf("vec%0d", v);
         run_txn(vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].waits, vecs[v].prdata,
                 vecs[v].slverr, vecs[v].stall, 1'b0,
                 vecs[v].e_paddr, vecs[v].e_rdata, vecs[v].e_err, 1'b0);
      end

`ifdef APB_MST_TIMEOUT_EN
      ctx = "timeout_rd";
      run_txn(1'b0, 12'h104, 32'h0, 0, 32'hCAFE_F00D, 1'b0, 1, 1'b1,
              12'h104, 32'h0, 1'b1, 1'b1);
      ctx = "timeout_wr";
      run_txn(1'b1, 12'h0F1, 32'h1357_9BDF, 0, 32'h0, 1'b0, 0, 1'b1,
              12'h0F0, 32'h0, 1'b1, 1'b1);
      ctx = "ready_at_limit";
      run_txn(1'b0, 12'h020, 32'h0, TB_TO - 1, 32'h7777_1111, 1'b0, 0, 1'b0,
              12'h020, 32'h7777_1111, 1'b0, 1'b0);
`else
      ctx = "long_wait";
      run_txn(1'b0, 12'h020, 32'h0, 40, 32'h7777_1111, 1'b0, 0, 1'b0,
              12'h020, 32'h7777_1111, 1'b0, 1'b0);
`endif

      // Reset asserted during the second ACCESS cycle drops the transfer.
      ctx = "mid_reset";
      cmd_valid_i = 1'b1; cmd_write_i = 1'b0; cmd_addr_i = 12'h020; cmd_wdata_i = 32'h0;
      @(negedge clk_i);
      cmd_valid_i = 1'b0;
      chk("setup_psel", 64'(psel_o), 64'(1));
      @(negedge clk_i);
      chk("acc1", 64'({psel_o, penable_o}), 64'(2'b11));
      @(negedge clk_i);
      chk("acc2", 64'({psel_o, penable_o}), 64'(2'b11));
      rst_i = 1'b1; pready_i = 1'b1; pslverr_i = 1'b1; prdata_i = 32'h1111_2222;
      @(negedge clk_i);
      chk("after_rst", 64'({psel_o, penable_o, rsp_valid_o}), 64'(0));
      rst_i = 1'b0; pready_i = 1'b0; pslverr_i = 1'b0;
      @(negedge clk_i);
      chk("released_cmd_ready", 64'(cmd_ready_o), 64'(1));
      for (int k = 0; k < 3; k++) begin
         @(negedge clk_i);
         chk("no_rsp", 64'({rsp_valid_o, busy_o}), 64'(0));
      end
      rsp_ready_i = 1'b0;

      // Random transfers against the transaction model.
      for (int n = 0; n < 25; n++) begin
         ctx    = $sformatf("rand%0d", n);
         r_wr   = 1'($urandom);
         r_addr = 12'($urandom);
         r_wd   = $urandom;
         r_prd  = $urandom;
         r_slv  = ($urandom_range(0, 3) == 0);
         ref_model(r_wr, r_addr, r_prd, r_slv, 1'b0, m_paddr, m_rdata, m_err, m_to);
         run_txn(r_wr, r_addr, r_wd, $urandom_range(0, TB_TO - 1 < 7 ? TB_TO - 1 : 7),
                 r_prd, r_slv, $urandom_range(0, 3), 1'b0, m_paddr, m_rdata, m_err, m_to);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
